// File: rtl/mux_21_pipe.sv
// mux_21_pipe: parameterised 2:1 data multiplexer.
// It has two outputs:
//   - mux_out_comb is a zero-latency combinational output.
//   - mux_out / mux_out_vld are registered one cycle later, which gives
//     downstream logic a clean timing break.
// The output register loads only on a qualified (in_vld=1) cycle.
// The valid flag is a plain one-cycle copy of in_vld.
module mux_21_pipe #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             sel,
    input  logic             in_vld,
    output logic [WIDTH-1:0] mux_out_comb,
    output logic [WIDTH-1:0] mux_out,
    output logic             mux_out_vld
);

    // Whole-word select: every bit comes from the same input, never mixed.
    function automatic logic [WIDTH-1:0] f_select(
        input logic             s,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        f_select = s ? b : a;
    endfunction

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_mux_out;
    logic             r_mux_out_vld;

    // Combinational select; shared by the comb output and the register input.
    always_comb begin
        w_mux = f_select(sel, in_0, in_1);
    end

    // Valid flag: one-cycle copy of in_vld; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mux_out_vld <= 1'b0;
        end else begin
            r_mux_out_vld <= in_vld;
        end
    end

    // Data register: loads only on qualified cycles, otherwise holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mux_out <= RST_VAL;
        end else if (in_vld) begin
            r_mux_out <= w_mux;
        end
    end

    assign mux_out_comb = w_mux;
    assign mux_out      = r_mux_out;
    assign mux_out_vld  = r_mux_out_vld;

endmodule

// File: tb/tb_mux_21_pipe.sv
// Directed self-checking bench for mux_21_pipe.
// Two instances are exercised:
//   - an 8-bit instance with reset value 8'h00;
//   - a 1-bit instance with reset value 1'b1, so that the reset value is
//     actually observable.
module tb_mux_21_pipe;

    logic       clk;
    logic       rst;
    logic [7:0] in_0;
    logic [7:0] in_1;
    logic       sel;
    logic       in_vld;
    logic [7:0] mux_out_comb;
    logic [7:0] mux_out;
    logic       mux_out_vld;

    logic       b_in_0;
    logic       b_in_1;
    logic       b_sel;
    logic       b_in_vld;
    logic       b_mux_out_comb;
    logic       b_mux_out;
    logic       b_mux_out_vld;

    int n_cmp;
    int n_fail;

    mux_21_pipe #(.WIDTH(8), .RST_VAL(8'h00)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .in_0         (in_0),
        .in_1         (in_1),
        .sel          (sel),
        .in_vld       (in_vld),
        .mux_out_comb (mux_out_comb),
        .mux_out      (mux_out),
        .mux_out_vld  (mux_out_vld)
    );

    mux_21_pipe #(.WIDTH(1), .RST_VAL(1'b1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_0         (b_in_0),
        .in_1         (b_in_1),
        .sel          (b_sel),
        .in_vld       (b_in_vld),
        .mux_out_comb (b_mux_out_comb),
        .mux_out      (b_mux_out),
        .mux_out_vld  (b_mux_out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_0     = 8'h12;
        in_1     = 8'h34;
        sel      = 1'b1;
        in_vld   = 1'b1;
        b_in_0   = 1'b0;
        b_in_1   = 1'b0;
        b_sel    = 1'b0;
        b_in_vld = 1'b0;
        #2;
        n_cmp++;
        if (mux_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out8: got %h want %h", mux_out, 8'h00);
        end
        n_cmp++;
        if (mux_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld8: got %b want 0", mux_out_vld);
        end
        n_cmp++;
        if (b_mux_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_out1: got %b want 1", b_mux_out);
        end
        n_cmp++;
        if (b_mux_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld1: got %b want 0", b_mux_out_vld);
        end
        // Reset held across an edge with in_vld=1 must keep the reset state.
        tick();
        n_cmp++;
        if (mux_out !== 8'h00 || mux_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h/%b want 00/0", mux_out, mux_out_vld);
        end
        n_cmp++;
        if (mux_out_comb !== 8'h34) begin
            n_fail++;
            $display("FAIL reset_comb: got %h want %h", mux_out_comb, 8'h34);
        end
        in_vld = 1'b0;
        rst    = 1'b0;
        tick();
    endtask

    task automatic test_comb_select();
        in_0 = 8'h00;
        in_1 = 8'h01;
        sel  = 1'b0;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'h00) begin
            n_fail++;
            $display("FAIL comb_sel0: got %h want %h", mux_out_comb, 8'h00);
        end
        in_0 = 8'h01;
        in_1 = 8'h00;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'h01) begin
            n_fail++;
            $display("FAIL comb_swap0: got %h want %h", mux_out_comb, 8'h01);
        end
        sel = 1'b1;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'h00) begin
            n_fail++;
            $display("FAIL comb_swap1: got %h want %h", mux_out_comb, 8'h00);
        end
        // Complementary nibbles: any bit mixing between inputs shows up here.
        in_0 = 8'hF0;
        in_1 = 8'h0F;
        sel  = 1'b0;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'hF0) begin
            n_fail++;
            $display("FAIL comb_bits0: got %h want %h", mux_out_comb, 8'hF0);
        end
        sel = 1'b1;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'h0F) begin
            n_fail++;
            $display("FAIL comb_bits1: got %h want %h", mux_out_comb, 8'h0F);
        end
        // Equal inputs give that value for either select.
        in_0 = 8'h6B;
        in_1 = 8'h6B;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'h6B) begin
            n_fail++;
            $display("FAIL comb_equal: got %h want %h", mux_out_comb, 8'h6B);
        end
    endtask

    task automatic test_registered();
        in_0   = 8'hA5;
        in_1   = 8'h3C;
        sel    = 1'b1;
        in_vld = 1'b1;
        tick();
        n_cmp++;
        if (mux_out !== 8'h3C || mux_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_load: got %h/%b want 3c/1", mux_out, mux_out_vld);
        end
        // sel changes while unqualified: register holds, comb follows.
        in_vld = 1'b0;
        sel    = 1'b0;
        tick();
        n_cmp++;
        if (mux_out !== 8'h3C || mux_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_hold: got %h/%b want 3c/0", mux_out, mux_out_vld);
        end
        n_cmp++;
        if (mux_out_comb !== 8'hA5) begin
            n_fail++;
            $display("FAIL reg_hold_comb: got %h want %h", mux_out_comb, 8'hA5);
        end
    endtask

    task automatic test_async_reset();
        // mux_out is 8'h3C here; load one more qualified result so a valid is in flight.
        in_0   = 8'h5E;
        sel    = 1'b0;
        in_vld = 1'b1;
        tick();
        n_cmp++;
        if (mux_out !== 8'h5E || mux_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst: got %h/%b want 5e/1", mux_out, mux_out_vld);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mux_out !== 8'h00 || mux_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got %h/%b want 00/0", mux_out, mux_out_vld);
        end
        in_1 = 8'hC3;
        sel  = 1'b1;
        #1;
        n_cmp++;
        if (mux_out_comb !== 8'hC3) begin
            n_fail++;
            $display("FAIL rst_comb: got %h want %h", mux_out_comb, 8'hC3);
        end
        // Release between edges; the first qualified edge afterwards captures.
        in_0 = 8'h77;
        sel  = 1'b0;
        rst  = 1'b0;
        tick();
        n_cmp++;
        if (mux_out !== 8'h77 || mux_out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release: got %h/%b want 77/1", mux_out, mux_out_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        logic       sel_q [4];
        exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
        sel_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        in_0   = 8'h11;
        in_1   = 8'h22;
        in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = sel_q[i];
            tick();
            n_cmp++;
            if (mux_out !== exp_q[i] || mux_out_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, mux_out, mux_out_vld, exp_q[i]);
            end
        end
        in_vld = 1'b0;
        tick();
        n_cmp++;
        if (mux_out !== 8'h22 || mux_out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got %h/%b want 22/0", mux_out, mux_out_vld);
        end
    endtask

    task automatic test_exhaustive_1bit();
        // Expected bit i for the index {sel,in_0,in_1}=i.
        logic [7:0] truth;
        logic [2:0] idx;
        truth = 8'b1010_1100;
        // The reset value must still be held: nothing has qualified the 1-bit instance yet.
        n_cmp++;
        if (b_mux_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ex_hold_rstval: got %b want 1", b_mux_out);
        end
        b_in_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idx    = 3'(i);
            b_sel  = idx[2];
            b_in_0 = idx[1];
            b_in_1 = idx[0];
            #1;
            n_cmp++;
            if (b_mux_out_comb !== truth[i]) begin
                n_fail++;
                $display("FAIL ex_comb[%0d]: got %b want %b", i, b_mux_out_comb, truth[i]);
            end
            tick();
            n_cmp++;
            if (b_mux_out !== truth[i] || b_mux_out_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL ex_reg[%0d]: got %b/%b want %b/1", i, b_mux_out, b_mux_out_vld, truth[i]);
            end
        end
        b_in_vld = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_comb_select();
        test_registered();
        test_async_reset();
        test_back_to_back();
        test_exhaustive_1bit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
